// File: rtl/dlsc_pcie_s6_outbound_cpl_if.sv
`default_nettype none
// ============================================================================
// Module      : dlsc_pcie_s6_outbound_cpl_if
// Description : Signal bundle for the outbound completion parser: TLP input,
//               header/payload outputs, error pulses and local ID.
// Revision    : 1.0 - initial release
// ============================================================================
interface dlsc_pcie_s6_outbound_cpl_if #(
    parameter int TAG = 5
);
    logic            rx_ready;
    logic            rx_valid;
    logic [31:0]     rx_data;
    logic            rx_last;

    logic            cpl_h_ready;
    logic            cpl_h_valid;
    logic [TAG-1:0]  cpl_h_tag;
    logic [6:0]      cpl_h_addr;
    logic [9:0]      cpl_h_len;
    logic            cpl_h_data;
    logic [11:0]     cpl_h_bytes;
    logic            cpl_h_last;
    logic [1:0]      cpl_h_resp;

    logic            cpl_d_ready;
    logic            cpl_d_valid;
    logic [31:0]     cpl_d_data;
    logic            cpl_d_last;

    logic            err_unexpected;
    logic            err_malformed;

    logic [7:0]      bus_number;
    logic [4:0]      dev_number;
    logic [2:0]      func_number;

    // slave is the parser; master is whatever feeds TLPs and sinks its output
    modport slave (
        output rx_ready,
        input  rx_valid, rx_data, rx_last,
        input  cpl_h_ready,
        output cpl_h_valid, cpl_h_tag, cpl_h_addr, cpl_h_len, cpl_h_data,
        output cpl_h_bytes, cpl_h_last, cpl_h_resp,
        input  cpl_d_ready,
        output cpl_d_valid, cpl_d_data, cpl_d_last,
        output err_unexpected, err_malformed,
        input  bus_number, dev_number, func_number
    );

    modport master (
        input  rx_ready,
        output rx_valid, rx_data, rx_last,
        output cpl_h_ready,
        input  cpl_h_valid, cpl_h_tag, cpl_h_addr, cpl_h_len, cpl_h_data,
        input  cpl_h_bytes, cpl_h_last, cpl_h_resp,
        output cpl_d_ready,
        input  cpl_d_valid, cpl_d_data, cpl_d_last,
        input  err_unexpected, err_malformed,
        output bus_number, dev_number, func_number
    );
endinterface
`default_nettype wire

// File: rtl/dlsc_pcie_s6_outbound_cpl.sv
`default_nettype none
// ============================================================================
// Module      : dlsc_pcie_s6_outbound_cpl
// Description : Parses 3DW completion TLPs into a header record and a payload
//               stream, dropping unexpected or malformed completions.
// Revision    : 1.0 - initial release
// ============================================================================
module dlsc_pcie_s6_outbound_cpl #(
    parameter int TAG = 5
) (
    input  wire                         clk,
    input  wire                         rst,
    dlsc_pcie_s6_outbound_cpl_if.slave  cpl_if
);

    typedef enum logic [2:0] {
        ST_H0   = 3'd0,
        ST_H1   = 3'd1,
        ST_H2   = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t      state_q,          state_d;
    logic        has_data_q,       has_data_d;
    logic [9:0]  len_q,            len_d;
    logic        type_ok_q,        type_ok_d;
    logic [2:0]  status_q,         status_d;
    logic [11:0] bytes_q,          bytes_d;
    logic [10:0] dw_rem_q,         dw_rem_d;
    logic        err_unexpected_q, err_unexpected_d;
    logic        err_malformed_q,  err_malformed_d;

    logic        rx_ready_c;
    logic        h_valid_c;
    logic        d_valid_c;
    logic        d_last_c;
    logic [10:0] len_ext;
    logic [12:0] bytes_ext;
    logic [12:0] end_sum;
    logic        id_match;
    logic        dw_one;
    logic [1:0]  resp_c;

    // Zero length encodes 1024 DWs and zero byte count encodes 4096 bytes
    assign len_ext   = {(len_q == 10'd0), len_q};
    assign bytes_ext = {(bytes_q == 12'd0), bytes_q};
    assign end_sum   = {11'd0, cpl_if.rx_data[1:0]} + bytes_ext + 13'd3;
    assign dw_one    = (dw_rem_q == 11'd1);

    assign id_match = type_ok_q &&
                      (cpl_if.rx_data[31:16] == {cpl_if.bus_number, cpl_if.dev_number, cpl_if.func_number}) &&
                      ((cpl_if.rx_data[15:8] >> TAG) == 8'd0);

    always_comb begin
        case (status_q)
            3'b000:  resp_c = 2'b00;
            3'b001:  resp_c = 2'b11;
            default: resp_c = 2'b10;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        has_data_d       = has_data_q;
        len_d            = len_q;
        type_ok_d        = type_ok_q;
        status_d         = status_q;
        bytes_d          = bytes_q;
        dw_rem_d         = dw_rem_q;
        err_unexpected_d = 1'b0;
        err_malformed_d  = 1'b0;
        rx_ready_c       = 1'b0;
        h_valid_c        = 1'b0;
        d_valid_c        = 1'b0;
        d_last_c         = 1'b0;

        case (state_q)
            ST_H0: begin
                rx_ready_c = 1'b1;
                if (cpl_if.rx_valid) begin
                    has_data_d = cpl_if.rx_data[30];
                    len_d      = cpl_if.rx_data[9:0];
                    type_ok_d  = !cpl_if.rx_data[29] && (cpl_if.rx_data[28:24] == 5'b01010);
                    if (cpl_if.rx_last) begin
                        err_malformed_d = 1'b1;
                    end else begin
                        state_d = ST_H1;
                    end
                end
            end
            ST_H1: begin
                rx_ready_c = 1'b1;
                if (cpl_if.rx_valid) begin
                    status_d = cpl_if.rx_data[15:13];
                    bytes_d  = cpl_if.rx_data[11:0];
                    if (cpl_if.rx_last) begin
                        err_malformed_d = 1'b1;
                        state_d         = ST_H0;
                    end else begin
                        state_d = ST_H2;
                    end
                end
            end
            ST_H2: begin
                if (id_match) begin
                    h_valid_c  = cpl_if.rx_valid;
                    rx_ready_c = cpl_if.cpl_h_ready;
                    if (cpl_if.rx_valid && cpl_if.cpl_h_ready) begin
                        dw_rem_d = len_ext;
                        if (has_data_q) begin
                            err_malformed_d = cpl_if.rx_last;
                            state_d         = cpl_if.rx_last ? ST_H0 : ST_DATA;
                        end else begin
                            err_malformed_d = !cpl_if.rx_last;
                            state_d         = cpl_if.rx_last ? ST_H0 : ST_DROP;
                        end
                    end
                end else begin
                    rx_ready_c = 1'b1;
                    if (cpl_if.rx_valid) begin
                        err_unexpected_d = 1'b1;
                        state_d          = cpl_if.rx_last ? ST_H0 : ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                d_valid_c  = cpl_if.rx_valid;
                d_last_c   = cpl_if.rx_last || dw_one;
                rx_ready_c = cpl_if.cpl_d_ready;
                if (cpl_if.rx_valid && cpl_if.cpl_d_ready) begin
                    dw_rem_d = dw_rem_q - 11'd1;
                    if (d_last_c) begin
                        err_malformed_d = (cpl_if.rx_last != dw_one);
                        state_d         = cpl_if.rx_last ? ST_H0 : ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                rx_ready_c = 1'b1;
                if (cpl_if.rx_valid && cpl_if.rx_last) begin
                    state_d = ST_H0;
                end
            end
            default: begin
                state_d = ST_H0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_H0;
            has_data_q       <= 1'b0;
            len_q            <= 10'd0;
            type_ok_q        <= 1'b0;
            status_q         <= 3'd0;
            bytes_q          <= 12'd0;
            dw_rem_q         <= 11'd0;
            err_unexpected_q <= 1'b0;
            err_malformed_q  <= 1'b0;
        end else begin
            state_q          <= state_d;
            has_data_q       <= has_data_d;
            len_q            <= len_d;
            type_ok_q        <= type_ok_d;
            status_q         <= status_d;
            bytes_q          <= bytes_d;
            dw_rem_q         <= dw_rem_d;
            err_unexpected_q <= err_unexpected_d;
            err_malformed_q  <= err_malformed_d;
        end
    end

    assign cpl_if.rx_ready       = rx_ready_c;
    assign cpl_if.cpl_h_valid    = h_valid_c;
    assign cpl_if.cpl_h_tag      = cpl_if.rx_data[TAG+7:8];
    assign cpl_if.cpl_h_addr     = cpl_if.rx_data[6:0];
    assign cpl_if.cpl_h_len      = has_data_q ? len_q : 10'd0;
    assign cpl_if.cpl_h_data     = has_data_q;
    assign cpl_if.cpl_h_bytes    = bytes_q;
    assign cpl_if.cpl_h_last     = has_data_q ? ((end_sum >> 2) == {2'b00, len_ext}) : 1'b1;
    assign cpl_if.cpl_h_resp     = resp_c;
    assign cpl_if.cpl_d_valid    = d_valid_c;
    assign cpl_if.cpl_d_data     = cpl_if.rx_data;
    assign cpl_if.cpl_d_last     = d_last_c;
    assign cpl_if.err_unexpected = err_unexpected_q;
    assign cpl_if.err_malformed  = err_malformed_q;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_pcie_s6_outbound_cpl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlsc_pcie_s6_outbound_cpl
// Description : Self-checking bench for the outbound completion parser.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlsc_pcie_s6_outbound_cpl;

    localparam int          TAG   = 5;
    localparam logic [7:0]  BUS   = 8'h5A;
    localparam logic [4:0]  DEV   = 5'h13;
    localparam logic [2:0]  FUNC  = 3'h2;
    localparam logic [15:0] MY_ID = {BUS, DEV, FUNC};

    logic clk = 1'b0;
    logic rst = 1'b1;

    dlsc_pcie_s6_outbound_cpl_if #(.TAG(TAG)) ifc ();
    dlsc_pcie_s6_outbound_cpl #(.TAG(TAG)) dut (.clk(clk), .rst(rst), .cpl_if(ifc));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TAG-1:0] tag;
        logic [6:0]     addr;
        logic [9:0]     len;
        logic           data;
        logic [11:0]    bytes;
        logic           last;
        logic [1:0]     resp;
    } hdr_t;

    hdr_t        obs_h[$], exp_h[$];
    logic [32:0] obs_d[$], exp_d[$];
    logic [31:0] tlp_q[$];
    hdr_t        mon_h;
    int n_u = 0, n_m = 0, exp_u = 0, exp_m = 0;
    int checks = 0, failures = 0;
    bit bp_en = 1'b0, d_hold = 1'b0;
    int gap_pct = 0;

    // Observe every handshake and error pulse between active edges
    always @(negedge clk) begin
        if (!rst) begin
            if (ifc.cpl_h_valid && ifc.cpl_h_ready) begin
                mon_h.tag   = ifc.cpl_h_tag;
                mon_h.addr  = ifc.cpl_h_addr;
                mon_h.len   = ifc.cpl_h_len;
                mon_h.data  = ifc.cpl_h_data;
                mon_h.bytes = ifc.cpl_h_bytes;
                mon_h.last  = ifc.cpl_h_last;
                mon_h.resp  = ifc.cpl_h_resp;
                obs_h.push_back(mon_h);
            end
            if (ifc.cpl_d_valid && ifc.cpl_d_ready) obs_d.push_back({ifc.cpl_d_last, ifc.cpl_d_data});
            if (ifc.err_unexpected) n_u++;
            if (ifc.err_malformed) n_m++;
        end
    end

    initial begin
        ifc.cpl_h_ready = 1'b1;
        ifc.cpl_d_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ifc.cpl_h_ready = bp_en ? ($urandom_range(0, 99) < 65) : 1'b1;
            ifc.cpl_d_ready = d_hold ? 1'b0 : (bp_en ? ($urandom_range(0, 99) < 65) : 1'b1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    // Reference model: expected header, payload and error counts for tlp_q
    task automatic model_tlp();
        logic [31:0] d0, d1, d2;
        hdr_t h;
        int lenx, bx, npay;
        if (tlp_q.size() < 3) begin
            exp_m++;
            return;
        end
        d0 = tlp_q[0]; d1 = tlp_q[1]; d2 = tlp_q[2];
        if (d0[29] != 1'b0 || d0[28:24] != 5'b01010 || d2[31:16] != MY_ID ||
            int'(d2[15:8]) >= (1 << TAG)) begin
            exp_u++;
            return;
        end
        lenx    = (d0[9:0] == 10'd0) ? 1024 : int'(d0[9:0]);
        bx      = (d1[11:0] == 12'd0) ? 4096 : int'(d1[11:0]);
        h.tag   = d2[TAG+7:8];
        h.addr  = d2[6:0];
        h.len   = d0[30] ? d0[9:0] : 10'd0;
        h.data  = d0[30];
        h.bytes = d1[11:0];
        h.last  = d0[30] ? ((int'(d2[1:0]) + bx + 3) / 4 == lenx) : 1'b1;
        case (d1[15:13])
            3'b000:  h.resp = 2'b00;
            3'b001:  h.resp = 2'b11;
            default: h.resp = 2'b10;
        endcase
        exp_h.push_back(h);
        npay = tlp_q.size() - 3;
        if (d0[30]) begin
            for (int i = 0; i < npay && i < lenx; i++)
                exp_d.push_back({(i == npay - 1) || (i == lenx - 1), tlp_q[3 + i]});
            if (npay != lenx) exp_m++;
        end else if (npay != 0) begin
            exp_m++;
        end
    endtask

    task automatic mk_tlp(input bit hd, input logic [9:0] len, input logic [2:0] st,
                          input logic [11:0] bytes, input logic [15:0] rid, input logic [7:0] tag,
                          input logic [6:0] addr, input bit bad_type, input int npay, input int keep);
        tlp_q.delete();
        tlp_q.push_back({1'b0, hd, bad_type, 5'b01010, 14'($urandom), len});
        tlp_q.push_back({16'($urandom), st, 1'b0, bytes});
        tlp_q.push_back({rid, tag, 1'b0, addr});
        for (int i = 0; i < npay; i++) tlp_q.push_back($urandom);
        while (keep > 0 && tlp_q.size() > keep) void'(tlp_q.pop_back());
        model_tlp();
    endtask

    task automatic send_tlp(input int ndw);
        int lim, n;
        bit acc;
        lim = (ndw > 0) ? ndw : tlp_q.size();
        for (int i = 0; i < lim; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                ifc.rx_valid = 1'b0;
                @(posedge clk); #1;
            end
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = tlp_q[i];
            ifc.rx_last  = (i == tlp_q.size() - 1);
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 300) begin
                @(negedge clk);
                acc = ifc.rx_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!acc) begin
                checks++; failures++;
                $display("FAIL rx_accept: got no rx_ready in %0d cycles, expected beat %0d accepted", n, i);
                ifc.rx_valid = 1'b0;
                return;
            end
        end
        ifc.rx_valid = 1'b0;
        ifc.rx_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        obs_h.delete(); exp_h.delete(); obs_d.delete(); exp_d.delete();
        n_u = 0; n_m = 0; exp_u = 0; exp_m = 0;
    endtask

    task automatic test_reset();
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 32'h4A00_0004;
        ifc.rx_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ifc.rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready: got %b expected 1", ifc.rx_ready); end
        checks++; if (ifc.cpl_h_valid !== 1'b0 || ifc.cpl_d_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got h=%b d=%b expected 0 0", ifc.cpl_h_valid, ifc.cpl_d_valid); end
        checks++; if (ifc.err_unexpected !== 1'b0 || ifc.err_malformed !== 1'b0) begin failures++; $display("FAIL reset_err: got u=%b m=%b expected 0 0", ifc.err_unexpected, ifc.err_malformed); end
        ifc.rx_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drain(2);
    endtask

    task automatic test_good_read();
        hdr_t h;
        clear_sb();
        mk_tlp(1'b1, 10'd4, 3'b000, 12'd16, MY_ID, 8'd3, 7'h00, 1'b0, 4, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 1) begin failures++; $display("FAIL good_hdr_count: got %0d expected 1", obs_h.size()); end
        if (obs_h.size() >= 1) begin
            h = obs_h[0];
            checks++;
            if (h.tag !== 5'd3 || h.len !== 10'd4 || h.last !== 1'b1 || h.resp !== 2'b00 ||
                h.data !== 1'b1 || h.bytes !== 12'd16 || h.addr !== 7'h00) begin
                failures++; $display("FAIL good_hdr: got %h expected tag 3 len 4 last 1 resp 0 data 1 bytes 16 addr 0", h);
            end
        end
        checks++; if (obs_d.size() !== 4) begin failures++; $display("FAIL good_pay_count: got %0d expected 4", obs_d.size()); end
        for (int i = 0; i < obs_d.size() && i < 4; i++) begin
            checks++;
            if (obs_d[i] !== {(i == 3), tlp_q[3 + i]}) begin failures++; $display("FAIL good_pay[%0d]: got %h expected %h", i, obs_d[i], {(i == 3), tlp_q[3 + i]}); end
        end
        checks++; if (n_u !== 0 || n_m !== 0) begin failures++; $display("FAIL good_err: got u=%0d m=%0d expected 0 0", n_u, n_m); end
    endtask

    task automatic test_split();
        clear_sb();
        mk_tlp(1'b1, 10'd2, 3'b000, 12'd20, MY_ID, 8'd9, 7'h04, 1'b0, 2, 0);
        send_tlp(0);
        mk_tlp(1'b1, 10'd3, 3'b000, 12'd12, MY_ID, 8'd9, 7'h0C, 1'b0, 3, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 2) begin failures++; $display("FAIL split_hdr_count: got %0d expected 2", obs_h.size()); end
        if (obs_h.size() == 2) begin
            checks++; if (obs_h[0].last !== 1'b0) begin failures++; $display("FAIL split_last0: got %b expected 0", obs_h[0].last); end
            checks++; if (obs_h[1].last !== 1'b1) begin failures++; $display("FAIL split_last1: got %b expected 1", obs_h[1].last); end
        end
        checks++; if (obs_d.size() !== 5 || n_m !== 0) begin failures++; $display("FAIL split_pay: got beats=%0d m=%0d expected 5 0", obs_d.size(), n_m); end
    endtask

    task automatic test_ur_nodata();
        hdr_t h;
        clear_sb();
        mk_tlp(1'b0, 10'd5, 3'b001, 12'd8, MY_ID, 8'd17, 7'h21, 1'b0, 0, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 1) begin failures++; $display("FAIL ur_hdr_count: got %0d expected 1", obs_h.size()); end
        if (obs_h.size() >= 1) begin
            h = obs_h[0];
            checks++;
            if (h.resp !== 2'b11 || h.len !== 10'd0 || h.data !== 1'b0 || h.last !== 1'b1 || h.tag !== 5'd17) begin
                failures++; $display("FAIL ur_hdr: got %h expected resp 3 len 0 data 0 last 1 tag 17", h);
            end
        end
        checks++; if (obs_d.size() !== 0 || n_m !== 0 || n_u !== 0) begin failures++; $display("FAIL ur_side: got beats=%0d m=%0d u=%0d expected 0 0 0", obs_d.size(), n_m, n_u); end
    endtask

    task automatic test_mismatch();
        clear_sb();
        mk_tlp(1'b1, 10'd2, 3'b000, 12'd8, MY_ID + 16'h0100, 8'd4, 7'h00, 1'b0, 2, 0);
        send_tlp(0);
        drain(3);
        checks++; if (obs_h.size() !== 0 || obs_d.size() !== 0) begin failures++; $display("FAIL mismatch_out: got h=%0d d=%0d expected 0 0", obs_h.size(), obs_d.size()); end
        checks++; if (n_u !== 1) begin failures++; $display("FAIL mismatch_err: got %0d expected 1", n_u); end
        mk_tlp(1'b1, 10'd1, 3'b000, 12'd4, MY_ID, 8'd7, 7'h00, 1'b0, 1, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 1 || (obs_h.size() == 1 && obs_h[0].tag !== 5'd7)) begin failures++; $display("FAIL mismatch_next: got count=%0d expected 1 header tag 7", obs_h.size()); end
        checks++; if (obs_d.size() !== 1 || n_u !== 1 || n_m !== 0) begin failures++; $display("FAIL mismatch_next_side: got d=%0d u=%0d m=%0d expected 1 1 0", obs_d.size(), n_u, n_m); end
    endtask

    task automatic test_malformed();
        clear_sb();
        mk_tlp(1'b1, 10'd4, 3'b000, 12'd16, MY_ID, 8'd5, 7'h00, 1'b0, 2, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_d.size() !== 2) begin failures++; $display("FAIL malformed_count: got %0d expected 2", obs_d.size()); end
        if (obs_d.size() == 2) begin
            checks++; if (obs_d[0][32] !== 1'b0 || obs_d[1][32] !== 1'b1) begin failures++; $display("FAIL malformed_last: got %b%b expected 01", obs_d[0][32], obs_d[1][32]); end
        end
        checks++; if (n_m !== 1 || n_u !== 0) begin failures++; $display("FAIL malformed_err: got m=%0d u=%0d expected 1 0", n_m, n_u); end
        mk_tlp(1'b1, 10'd1, 3'b100, 12'd4, MY_ID, 8'd30, 7'h00, 1'b0, 1, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 2 || (obs_h.size() == 2 && (obs_h[1].tag !== 5'd30 || obs_h[1].resp !== 2'b10))) begin failures++; $display("FAIL malformed_next: got count=%0d expected 2 with tag 30 resp 2", obs_h.size()); end
    endtask

    task automatic test_random();
        int k, npay, keep;
        bit hd, bad;
        logic [9:0]  len;
        logic [2:0]  st;
        logic [11:0] bytes;
        logic [6:0]  addr;
        logic [7:0]  tag;
        logic [15:0] rid;
        clear_sb();
        bp_en   = 1'b1;
        gap_pct = 20;
        for (int t = 0; t < 1000; t++) begin
            k     = $urandom_range(0, 99);
            hd    = ($urandom_range(0, 9) != 0);
            len   = 10'($urandom_range(1, 8));
            case ($urandom_range(0, 3))
                0: st = 3'b000; 1: st = 3'b001; 2: st = 3'b100; default: st = 3'($urandom);
            endcase
            addr  = 7'($urandom);
            bytes = $urandom_range(0, 1) ? 12'(int'(len) * 4 - int'(addr[1:0])) : 12'($urandom);
            tag   = 8'($urandom_range(0, 31));
            rid   = MY_ID;
            bad   = 1'b0;
            npay  = hd ? int'(len) : 0;
            keep  = 0;
            if (k < 5)       rid = MY_ID ^ 16'(1 << $urandom_range(0, 15));
            else if (k < 10) tag = 8'($urandom_range(32, 255));
            else if (k < 13) bad = 1'b1;
            else if (k < 19) npay = hd ? ((len == 10'd1 || $urandom_range(0, 1)) ? int'(len) + 2 : int'(len) - 1) : 1;
            else if (k < 21) keep = $urandom_range(1, 2);
            mk_tlp(hd, len, st, bytes, rid, tag, addr, bad, npay, keep);
            send_tlp(0);
        end
        bp_en   = 1'b0;
        gap_pct = 0;
        drain(10);
        checks++; if (obs_h.size() !== exp_h.size()) begin failures++; $display("FAIL rand_hdr_count: got %0d expected %0d", obs_h.size(), exp_h.size()); end
        for (int i = 0; i < obs_h.size() && i < exp_h.size(); i++) begin
            checks++;
            if (obs_h[i] !== exp_h[i]) begin failures++; $display("FAIL rand_hdr[%0d]: got %h expected %h", i, obs_h[i], exp_h[i]); end
        end
        checks++; if (obs_d.size() !== exp_d.size()) begin failures++; $display("FAIL rand_pay_count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            checks++;
            if (obs_d[i] !== exp_d[i]) begin failures++; $display("FAIL rand_pay[%0d]: got %h expected %h", i, obs_d[i], exp_d[i]); end
        end
        checks++; if (n_u !== exp_u) begin failures++; $display("FAIL rand_err_unexpected: got %0d expected %0d", n_u, exp_u); end
        checks++; if (n_m !== exp_m) begin failures++; $display("FAIL rand_err_malformed: got %0d expected %0d", n_m, exp_m); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        d_hold = 1'b1;
        drain(2);
        mk_tlp(1'b1, 10'd4, 3'b000, 12'd16, MY_ID, 8'd2, 7'h00, 1'b0, 4, 0);
        send_tlp(3);
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = tlp_q[3];
        ifc.rx_last  = 1'b0;
        drain(2);
        @(negedge clk);
        checks++; if (ifc.rx_ready !== 1'b0 || ifc.cpl_d_valid !== 1'b1) begin failures++; $display("FAIL midrst_stall: got ready=%b dvalid=%b expected 0 1", ifc.rx_ready, ifc.cpl_d_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ifc.rx_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", ifc.rx_ready); end
        checks++; if (ifc.cpl_d_valid !== 1'b0 || ifc.cpl_h_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got d=%b h=%b expected 0 0", ifc.cpl_d_valid, ifc.cpl_h_valid); end
        ifc.rx_valid = 1'b0;
        d_hold       = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        drain(2);
        clear_sb();
        mk_tlp(1'b1, 10'd2, 3'b000, 12'd8, MY_ID, 8'd11, 7'h00, 1'b0, 2, 0);
        send_tlp(0);
        drain(4);
        checks++; if (obs_h.size() !== 1 || obs_d.size() !== 2) begin failures++; $display("FAIL midrst_after: got h=%0d d=%0d expected 1 2", obs_h.size(), obs_d.size()); end
        checks++; if (obs_d.size() == 2 && obs_d[1] !== {1'b1, tlp_q[4]}) begin failures++; $display("FAIL midrst_data: got %h expected %h", obs_d[1], {1'b1, tlp_q[4]}); end
    endtask

    initial begin
        ifc.rx_valid    = 1'b0;
        ifc.rx_data     = 32'd0;
        ifc.rx_last     = 1'b0;
        ifc.bus_number  = BUS;
        ifc.dev_number  = DEV;
        ifc.func_number = FUNC;
        test_reset();
        test_good_read();
        test_split();
        test_ur_nodata();
        test_mismatch();
        test_malformed();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dlsc_pcie_s6_outbound_cpl.md
Name: dlsc_pcie_s6_outbound_cpl

Overview:
- Receive-side completion parser for the S6 PCIe outbound (local-initiated) read path.
- Consumes a 32-bit completion TLP stream (3DW header plus optional payload) from the RX demux.
- Checks the requester ID and tag, maps the completion status to an AXI response, and emits one header record per TLP plus a separate payload stream.
- Feeds the outbound read-reorder/tag tracker, which reassembles AXI read data.

Parameters:
- TAG, 5, width of the tag range accepted; tags with tag[7:TAG] != 0 are rejected.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_ready  out  1  TLP input ready
- rx_valid  in  1  TLP input valid
- rx_data  in  32  TLP DW (header DW0 first)
- rx_last  in  1  final DW of TLP
- cpl_h_ready  in  1  header sink ready
- cpl_h_valid  out  1  header valid
- cpl_h_tag  out  TAG  completion tag
- cpl_h_addr  out  7  lower address
- cpl_h_len  out  10  payload DWs (0 when no data; 1024 encoded as 0 is reported as 10'd0 only with has-data=1)
- cpl_h_data  out  1  TLP carries payload
- cpl_h_bytes  out  12  remaining byte count
- cpl_h_last  out  1  this TLP completes the request
- cpl_h_resp  out  2  AXI response
- cpl_d_ready  in  1  payload sink ready
- cpl_d_valid  out  1  payload valid
- cpl_d_data  out  32  payload DW
- cpl_d_last  out  1  final payload DW of TLP
- err_unexpected  out  1  one-cycle pulse: TLP dropped (ID/tag/type mismatch)
- err_malformed  out  1  one-cycle pulse: length and rx_last disagree
- bus_number  in  8  local bus number
- dev_number  in  5  local device number
- func_number  in  3  local function number

Behaviour:
- Reset state: ST_H0, all counters 0, err pulses 0. No outputs are valid during reset.
- Handshake: a beat transfers when valid && ready.
- States:
  - ST_H0:
    - rx_ready=1.
    - Capture has_data=DW0[30], len=DW0[9:0], type_ok=(DW0[29]==0 && DW0[28:24]==5'b01010).
    - Go to ST_H1. If rx_last is seen here, pulse err_malformed and stay in ST_H0.
  - ST_H1:
    - rx_ready=1.
    - Capture status=DW1[15:13], bytes=DW1[11:0].
    - Go to ST_H2. An early rx_last gives err_malformed and a return to ST_H0.
  - ST_H2:
    - Compute match = type_ok && DW2[31:16]=={bus,dev,func} && DW2[15:8]>>TAG==0.
    - If match: cpl_h_valid=rx_valid; rx_ready=cpl_h_ready.
    - If no match: rx_ready=1 and no header is emitted; on accept pulse err_unexpected, then go to ST_H0 if rx_last, else ST_DROP.
    - On a matched accept: go to ST_DATA if has_data, else ST_H0. rx_last disagreeing with has_data pulses err_malformed, with recovery via ST_DROP or ST_H0.
  - ST_DATA:
    - Pass-through: cpl_d_valid=rx_valid, cpl_d_data=rx_data, rx_ready=cpl_d_ready.
    - cpl_d_last = rx_last || (dw_rem==1).
    - dw_rem is loaded in ST_H2 with len (0 means 1024, so 11 bits) and decrements per accepted beat.
    - On an accept with cpl_d_last: if rx_last != (dw_rem==1), pulse err_malformed. Next state is ST_H0 if rx_last, else ST_DROP.
  - ST_DROP: rx_ready=1; discard beats until rx_last, then go to ST_H0.
- Header fields are combinational from the captured registers plus DW2:
  - cpl_h_tag = DW2[TAG+7:8].
  - cpl_h_addr = DW2[6:0].
  - cpl_h_len = has_data ? len : 0.
- cpl_h_resp mapping: status 000 (SC) gives 2'b00; 001 (UR) gives 2'b11; 100 (CA) gives 2'b10; any other value gives 2'b10.
- cpl_h_last = has_data ? ((addr[1:0] + bytes + 3) >> 2 == len_ext) : 1. Use 13-bit arithmetic, with bytes==0 treated as 4096.
- Outputs must not depend combinationally on cpl_*_ready, except rx_ready.
- Reset mid-TLP: return to ST_H0 immediately. The remainder of a partially received TLP is then parsed as a new header; upstream resets together with this block.

Test Plan:
- Good read, SC, len=4, bytes=16, addr=0x00, ID match, tag=3 -> header {tag 3, len 4, last 1, resp 00, data 1}; 4 payload beats with cpl_d_last on beat 4; no errors.
- Split completion: len=2, bytes=20, addr=0x04 -> cpl_h_last=0; next TLP len=3, bytes=12 -> cpl_h_last=1.
- UR completion without data (DW0[30]=0, status 001, rx_last on DW2) -> header resp=11, len=0, data=0, last=1; no cpl_d_valid.
- ReqID mismatch (bus+1) with len=2 payload -> no cpl_h_valid, no cpl_d_valid; err_unexpected pulses once; next good TLP parses correctly.
- len=4 but rx_last on payload beat 2 -> cpl_d_last on beat 2, err_malformed pulses, state returns to ST_H0.
- Random backpressure on cpl_h_ready/cpl_d_ready and gaps in rx_valid over 1000 TLPs -> payload matches a scoreboard with no loss or duplication; assert rst mid-payload -> rx_ready returns to 1 in ST_H0 on the next cycle.
